id_hazard_scheduler: RTL and testbench

Sequencing controller for the ID-stage register file of the 5-stage MIPS32 pipeline. It tracks in-flight destination registers in a shadow EX/MEM pipeline. It detects load-use hazards and multi-cycle load waits, and drives the stall, bubble and freeze controls. It also generates the 2-bit WB-to-ID bypass select that the register file uses on same-cycle write/read collisions.

---
 rtl/id_hazard_scheduler.sv | 159 +++++++++++++++
 tb/tb_id_hazard_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// id_hazard_scheduler
//
// ID-stage sequencing controller for a 5-stage MIPS32 pipeline. A shadow copy
// of the EX and MEM pipeline slots ({valid, dest, regwrite, load}) is kept so
// that load-use hazards and multi-cycle load waits can be detected without
// looking into the datapath registers.
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   Read_Address_1_ID/_2_ID     rs / rt indices read in ID
//   Uses_Rs_ID / Uses_Rt_ID     ID instruction actually consumes rs / rt
//   Dest_Register_ID            destination of the ID instruction
//   RegWrite_ID / MemRead_ID    ID instruction writes the RF / is a load
//   Flush_ID                    squash the ID instruction
//   Write_Register_WB           WB destination index
//   RegWrite_WB                 WB write enable
//   Mem_Ready                   data memory finished the load in MEM
//   Stall_ID                    hold PC and IF/ID
//   Bubble_EX                   load a NOP into ID/EX
//   Freeze                      hold ID/EX, EX/MEM, MEM/WB
//   ID_Register_Write_to_Read   [0] rs bypass from WB, [1] rt bypass from WB
//   Stall_Count                 saturating count of Stall_ID cycles
//
// Handshake: there is no valid/ready pair here. Mem_Ready acts as the "ready"
// of the load sitting in MEM; the pipeline only advances on an edge where the
// MEM slot does not hold a load that is still waiting for Mem_Ready.
// ---------------------------------------------------------------------------
module id_hazard_scheduler #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4:0]             Read_Address_1_ID,
  input  logic [4:0]             Read_Address_2_ID,
  input  logic                   Uses_Rs_ID,
  input  logic                   Uses_Rt_ID,
  input  logic [4:0]             Dest_Register_ID,
  input  logic                   RegWrite_ID,
  input  logic                   MemRead_ID,
  input  logic                   Flush_ID,
  input  logic [4:0]             Write_Register_WB,
  input  logic                   RegWrite_WB,
  input  logic                   Mem_Ready,
  output logic                   Stall_ID,
  output logic                   Bubble_EX,
  output logic                   Freeze,
  output logic [1:0]             ID_Register_Write_to_Read,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  // Shadow EX slot
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_load_q, ex_load_d;

  // Shadow MEM slot
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_dest_q, mem_dest_d;
  logic       mem_regwrite_q, mem_regwrite_d;
  logic       mem_load_q, mem_load_d;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_hazard_src;
  logic load_use;
  logic freeze_int;
  logic stall_int;
  logic bubble_int;
  logic [1:0] bypass_int;

  // Register $0 is hard-wired zero, so a write to it is never a producer.
  assign ex_hazard_src = ex_valid_q & ex_regwrite_q & (ex_dest_q != 5'd0);

  assign load_use = ex_hazard_src & ex_load_q &
                    ((Uses_Rs_ID & (ex_dest_q == Read_Address_1_ID)) |
                     (Uses_Rt_ID & (ex_dest_q == Read_Address_2_ID)));

  assign freeze_int = mem_valid_q & mem_load_q & ~Mem_Ready;

  // A flushed ID instruction is discarded anyway, so it cannot cause a stall.
  // While frozen, ID/EX is held, so no bubble is injected; the hazard is
  // simply seen again once the freeze lifts.
  assign stall_int  = freeze_int | (load_use & ~Flush_ID);
  assign bubble_int = load_use & ~Flush_ID & ~freeze_int;

  assign bypass_int[0] = RegWrite_WB & (Write_Register_WB != 5'd0) &
                         (Write_Register_WB == Read_Address_1_ID);
  assign bypass_int[1] = RegWrite_WB & (Write_Register_WB != 5'd0) &
                         (Write_Register_WB == Read_Address_2_ID);

  // Outputs are quiet during the reset cycle even though the slot registers
  // still hold pre-reset contents until the edge.
  assign Stall_ID                  = ~Reset & stall_int;
  assign Bubble_EX                 = ~Reset & bubble_int;
  assign Freeze                    = ~Reset & freeze_int;
  assign ID_Register_Write_to_Read = Reset ? 2'b00 : bypass_int;
  assign Stall_Count               = Reset ? '0 : stall_cnt_q;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_dest_d      = ex_dest_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_load_d      = ex_load_q;
    mem_valid_d    = mem_valid_q;
    mem_dest_d     = mem_dest_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_load_d     = mem_load_q;
    stall_cnt_d    = stall_cnt_q;

    if (!freeze_int) begin
      mem_valid_d    = ex_valid_q;
      mem_dest_d     = ex_dest_q;
      mem_regwrite_d = ex_regwrite_q;
      mem_load_d     = ex_load_q;
      if (!stall_int && !Flush_ID) begin
        ex_valid_d    = 1'b1;
        ex_dest_d     = Dest_Register_ID;
        ex_regwrite_d = RegWrite_ID;
        ex_load_d     = MemRead_ID;
      end else begin
        ex_valid_d    = 1'b0;
        ex_dest_d     = 5'd0;
        ex_regwrite_d = 1'b0;
        ex_load_d     = 1'b0;
      end
    end

    if (stall_int && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q     <= 1'b0;
      ex_dest_q      <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_load_q      <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= 5'd0;
      mem_regwrite_q <= 1'b0;
      mem_load_q     <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_load_q      <= ex_load_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_load_q     <= mem_load_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
module tb_id_hazard_scheduler;

  // Narrow counter so saturation is reached within a short directed run.
  localparam int CW = 3;
  localparam int EW = CW + 5;

  logic          clk;
  logic          reset;
  logic [4:0]    ra1, ra2, dest_id, wb_reg;
  logic          uses_rs, uses_rt, rw_id, mr_id, flush, rw_wb, mem_ready;
  logic          stall, bubble, freeze;
  logic [1:0]    byp;
  logic [CW-1:0] cnt;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  id_hazard_scheduler #(.STALL_CNT_W(CW)) dut (
    .Clk                       (clk),
    .Reset                     (reset),
    .Read_Address_1_ID         (ra1),
    .Read_Address_2_ID         (ra2),
    .Uses_Rs_ID                (uses_rs),
    .Uses_Rt_ID                (uses_rt),
    .Dest_Register_ID          (dest_id),
    .RegWrite_ID               (rw_id),
    .MemRead_ID                (mr_id),
    .Flush_ID                  (flush),
    .Write_Register_WB         (wb_reg),
    .RegWrite_WB               (rw_wb),
    .Mem_Ready                 (mem_ready),
    .Stall_ID                  (stall),
    .Bubble_EX                 (bubble),
    .Freeze                    (freeze),
    .ID_Register_Write_to_Read (byp),
    .Stall_Count               (cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations for the current cycle are checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, ".stall"},  {31'd0, stall},  {31'd0, e[EW-1]});
      check_eq({t, ".bubble"}, {31'd0, bubble}, {31'd0, e[EW-2]});
      check_eq({t, ".freeze"}, {31'd0, freeze}, {31'd0, e[EW-3]});
      check_eq({t, ".bypass"}, {30'd0, byp},    {30'd0, e[CW+1:CW]});
      check_eq({t, ".count"},  32'(cnt),        32'(e[CW-1:0]));
    end
  end

  // Driver tasks
  task automatic set_nop();
    dest_id = 5'd0; rw_id = 1'b0; mr_id = 1'b0;
    ra1 = 5'd0; ra2 = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] d, input logic rw, input logic ld,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic urs, input logic urt);
    dest_id = d; rw_id = rw; mr_id = ld;
    ra1 = a1; ra2 = a2; uses_rs = urs; uses_rt = urt;
  endtask

  // Queue the expectation for the inputs currently applied, then advance.
  task automatic step(input string tag, input logic st, input logic bu,
                      input logic fr, input logic [1:0] bp, input logic [CW-1:0] c);
    exp_q.push_back({st, bu, fr, bp, c});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; rw_wb = 1'b0; wb_reg = 5'd0; mem_ready = 1'b1;
    set_nop();
    @(posedge clk);
    #1;

    // Reset: bypass condition present but outputs must stay low.
    rw_wb = 1'b1; wb_reg = 5'd5; ra1 = 5'd5;
    step("rst0", 0, 0, 0, 2'b00, 0);
    rw_wb = 1'b0; wb_reg = 5'd0; set_nop();
    step("rst1", 0, 0, 0, 2'b00, 0);
    reset = 1'b0;

    // Load-use on rs: lw $8 ; add $9,$8,$1
    set_id(5'd8, 1, 1, 5'd1, 5'd0, 1, 0);
    step("lu_lw", 0, 0, 0, 2'b00, 0);
    set_id(5'd9, 1, 0, 5'd8, 5'd1, 1, 1);
    step("lu_stall", 1, 1, 0, 2'b00, 0);
    step("lu_go", 0, 0, 0, 2'b00, 1);
    set_nop();
    step("lu_after", 0, 0, 0, 2'b00, 1);

    // Load to $0 never stalls
    set_id(5'd0, 1, 1, 5'd1, 5'd0, 1, 0);
    step("z_lw", 0, 0, 0, 2'b00, 1);
    set_id(5'd9, 1, 0, 5'd0, 5'd0, 1, 1);
    step("z_use", 0, 0, 0, 2'b00, 1);
    set_nop();
    step("z_after", 0, 0, 0, 2'b00, 1);

    // WB bypass
    rw_wb = 1'b1; wb_reg = 5'd5; ra1 = 5'd7; ra2 = 5'd5;
    step("byp_rt", 0, 0, 0, 2'b10, 1);
    ra1 = 5'd5;
    step("byp_both", 0, 0, 0, 2'b11, 1);
    wb_reg = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    step("byp_r0", 0, 0, 0, 2'b00, 1);
    rw_wb = 1'b0; wb_reg = 5'd5; ra1 = 5'd5;
    step("byp_nowe", 0, 0, 0, 2'b00, 1);
    wb_reg = 5'd0; set_nop();

    // Freeze for 3 cycles
    set_id(5'd10, 1, 1, 5'd2, 5'd0, 1, 0);
    step("fz_lw", 0, 0, 0, 2'b00, 1);
    set_nop(); mem_ready = 1'b0;
    step("fz_ex", 0, 0, 0, 2'b00, 1);
    step("fz1", 1, 0, 1, 2'b00, 1);
    step("fz2", 1, 0, 1, 2'b00, 2);
    step("fz3", 1, 0, 1, 2'b00, 3);
    mem_ready = 1'b1;
    step("fz_rel", 0, 0, 0, 2'b00, 4);
    mem_ready = 1'b0;  // load must have left MEM on the release edge
    step("fz_gone", 0, 0, 0, 2'b00, 4);
    mem_ready = 1'b1;

    // Freeze takes priority over a pending load-use
    set_id(5'd11, 1, 1, 5'd3, 5'd0, 1, 0);
    step("pr_lw11", 0, 0, 0, 2'b00, 4);
    set_id(5'd12, 1, 1, 5'd4, 5'd0, 1, 0); mem_ready = 1'b0;
    step("pr_lw12", 0, 0, 0, 2'b00, 4);
    set_id(5'd13, 1, 0, 5'd12, 5'd0, 1, 1);
    step("pr_frz", 1, 0, 1, 2'b00, 4);
    mem_ready = 1'b1;
    step("pr_lu", 1, 1, 0, 2'b00, 5);
    step("pr_go", 0, 0, 0, 2'b00, 6);
    set_nop();
    step("pr_after", 0, 0, 0, 2'b00, 6);

    // Flush over load-use; flushed load must not reach EX
    set_id(5'd14, 1, 1, 5'd1, 5'd0, 1, 0);
    step("fl_lw14", 0, 0, 0, 2'b00, 6);
    set_id(5'd15, 1, 1, 5'd14, 5'd0, 1, 0); flush = 1'b1;
    step("fl_flush", 0, 0, 0, 2'b00, 6);
    flush = 1'b0; set_id(5'd16, 1, 0, 5'd15, 5'd14, 1, 1);
    step("fl_exinv", 0, 0, 0, 2'b00, 6);

    // Back-to-back loads to $8, counter saturates at 7
    set_id(5'd8, 1, 1, 5'd1, 5'd0, 1, 0);
    step("bb_lw1", 0, 0, 0, 2'b00, 6);
    set_id(5'd8, 1, 1, 5'd8, 5'd0, 1, 0);
    step("bb_lw2st", 1, 1, 0, 2'b00, 6);
    step("bb_lw2go", 0, 0, 0, 2'b00, 7);
    set_id(5'd9, 1, 0, 5'd8, 5'd0, 1, 0);
    step("bb_addst", 1, 1, 0, 2'b00, 7);
    step("bb_sat", 0, 0, 0, 2'b00, 7);
    set_nop();
    step("bb_after", 0, 0, 0, 2'b00, 7);

    // Reset during a freeze
    set_id(5'd20, 1, 1, 5'd1, 5'd0, 1, 0);
    step("rf_lw", 0, 0, 0, 2'b00, 7);
    set_nop(); mem_ready = 1'b0;
    step("rf_ex", 0, 0, 0, 2'b00, 7);
    step("rf_frz", 1, 0, 1, 2'b00, 7);
    reset = 1'b1; rw_wb = 1'b1; wb_reg = 5'd5; ra1 = 5'd5; ra2 = 5'd5;
    step("rf_rst", 0, 0, 0, 2'b00, 0);
    reset = 1'b0; rw_wb = 1'b0; wb_reg = 5'd0; set_nop();
    step("rf_post", 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b1;
    step("rf_idle", 0, 0, 0, 2'b00, 0);

    @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
